// File: rtl/mig_eval_engine_pkg.sv
// Shared types and sizing for the MIG evaluation engine.
// Operand and gate layouts are sized from the package defaults MIG_NUM_IN / MIG_NUM_GATES.
package mig_eval_pkg;

  function automatic int sel_width(input int n_in, input int n_gates);
    return $clog2(1 + n_in + n_gates);
  endfunction

  localparam int MIG_NUM_IN    = 7;
  localparam int MIG_NUM_GATES = 8;
  localparam int MIG_SEL_W     = sel_width(MIG_NUM_IN, MIG_NUM_GATES);
  localparam int MIG_ADDR_W    = $clog2(MIG_NUM_GATES);
  localparam int MIG_LEN_W     = MIG_ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  typedef struct packed {
    logic                 inv;
    logic [MIG_SEL_W-1:0] sel;
  } operand_t;

  typedef struct packed {
    operand_t c;
    operand_t a;
    operand_t b;
  } gate_t;

endpackage

// File: rtl/mig_eval_engine_if.sv
// Configuration, input-vector and result handshake bundle of the MIG evaluation engine.
interface mig_eval_engine_if;
  import mig_eval_pkg::*;

  logic                  cfg_we;
  logic [MIG_ADDR_W-1:0] cfg_addr;
  gate_t                 cfg_data;
  logic [MIG_LEN_W-1:0]  cfg_len;
  logic                  cfg_out_inv;
  logic                  cfg_ready;

  logic                  in_valid;
  logic                  in_ready;
  logic [MIG_NUM_IN-1:0] in_x;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_bit;
  logic                  out_last;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_len, cfg_out_inv,
    output in_valid, in_x, out_ready,
    input  cfg_ready, in_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_len, cfg_out_inv,
    input  in_valid, in_x, out_ready,
    output cfg_ready, in_ready, out_valid, out_bit, out_last
  );

endinterface

// File: rtl/mig_eval_engine_operand_mux.sv
// Resolves one operand selector to a bit from {constant 0, input vector, node registers}.
// Selectors past the last node read 0; the inv flag complements the picked bit.
module mig_operand_mux
  import mig_eval_pkg::*;
#(
  parameter int NUM_IN    = MIG_NUM_IN,
  parameter int NUM_GATES = MIG_NUM_GATES
) (
  input  operand_t              op_i,
  input  logic [NUM_IN-1:0]     x_i,
  input  logic [NUM_GATES-1:0]  node_i,
  output logic                  bit_o
);

  localparam int SRC_N = 1 + NUM_IN + NUM_GATES;

  logic [SRC_N-1:0] src;
  logic             raw;

  assign src = {node_i, x_i, 1'b0};

  always_comb begin
    raw = 1'b0;
    if (int'(op_i.sel) < SRC_N) raw = src[op_i.sel];
    bit_o = raw ^ op_i.inv;
  end

endmodule

// File: rtl/mig_eval_engine.sv
// Sequential MIG evaluator: one majority node per cycle from a loadable gate program.
// Optional MIG_EVAL_SWEEP_EN adds sweep_start for internal truth-table enumeration.
module mig_eval_engine
  import mig_eval_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MIG_EVAL_SWEEP_EN
  input  logic                 sweep_start,
`endif
  mig_eval_engine_if.slave     bus
);

  localparam int NUM_IN    = MIG_NUM_IN;
  localparam int NUM_GATES = MIG_NUM_GATES;
  localparam int ADDR_W    = MIG_ADDR_W;
  localparam int LEN_W     = MIG_LEN_W;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     gidx_q, gidx_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [NUM_IN-1:0]     x_q, x_d;
  logic                  inv_q, inv_d;
  logic [NUM_GATES-1:0]  node_q, node_d;
  logic                  obit_q, obit_d;
`ifdef MIG_EVAL_SWEEP_EN
  logic                  sweep_q, sweep_d;
`endif

  gate_t                 prog_q [NUM_GATES];
  gate_t                 cur;
  logic                  op_a, op_b, op_c, maj;
  logic                  last_gate;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    if (l == '0)                          return LEN_W'(1);
    else if (int'(l) > NUM_GATES)         return LEN_W'(NUM_GATES);
    else                                  return l;
  endfunction

  // Program memory carries no reset; writes only land while the engine is idle.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state_q == IDLE)) prog_q[bus.cfg_addr] <= bus.cfg_data;
  end

  assign cur = prog_q[gidx_q];

  mig_operand_mux #(.NUM_IN(NUM_IN), .NUM_GATES(NUM_GATES)) u_mux_a (
    .op_i(cur.a), .x_i(x_q), .node_i(node_q), .bit_o(op_a)
  );
  mig_operand_mux #(.NUM_IN(NUM_IN), .NUM_GATES(NUM_GATES)) u_mux_b (
    .op_i(cur.b), .x_i(x_q), .node_i(node_q), .bit_o(op_b)
  );
  mig_operand_mux #(.NUM_IN(NUM_IN), .NUM_GATES(NUM_GATES)) u_mux_c (
    .op_i(cur.c), .x_i(x_q), .node_i(node_q), .bit_o(op_c)
  );

  assign maj       = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
  assign last_gate = ({1'b0, gidx_q} == (len_q - LEN_W'(1)));

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    len_d   = len_q;
    x_d     = x_q;
    inv_d   = inv_q;
    node_d  = node_q;
    obit_d  = obit_q;
`ifdef MIG_EVAL_SWEEP_EN
    sweep_d = sweep_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = EVAL;
          gidx_d  = '0;
          len_d   = clamp_len(bus.cfg_len);
          x_d     = bus.in_x;
          inv_d   = bus.cfg_out_inv;
          node_d  = '0;
        end
`ifdef MIG_EVAL_SWEEP_EN
        else if (sweep_start) begin
          state_d = EVAL;
          gidx_d  = '0;
          len_d   = clamp_len(bus.cfg_len);
          x_d     = '0;
          inv_d   = bus.cfg_out_inv;
          node_d  = '0;
          sweep_d = 1'b1;
        end
`endif
      end
      EVAL: begin
        node_d[gidx_q] = maj;
        gidx_d         = gidx_q + ADDR_W'(1);
        if (last_gate) begin
          state_d = DONE;
          obit_d  = maj ^ inv_q;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
`ifdef MIG_EVAL_SWEEP_EN
          sweep_d = 1'b0;
          // A sweep chains straight into the next vector without revisiting IDLE.
          if (sweep_q && !(&x_q)) begin
            state_d = EVAL;
            sweep_d = 1'b1;
            x_d     = x_q + NUM_IN'(1);
            gidx_d  = '0;
            node_d  = '0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    bus.cfg_ready = (state_q == IDLE);
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.out_bit   = obit_q;
`ifdef MIG_EVAL_SWEEP_EN
    bus.out_last  = sweep_q && (&x_q) && (state_q == DONE);
`else
    bus.out_last  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      len_q   <= LEN_W'(1);
      x_q     <= '0;
      inv_q   <= 1'b0;
      node_q  <= '0;
      obit_q  <= 1'b0;
`ifdef MIG_EVAL_SWEEP_EN
      sweep_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      len_q   <= len_d;
      x_q     <= x_d;
      inv_q   <= inv_d;
      node_q  <= node_d;
      obit_q  <= obit_d;
`ifdef MIG_EVAL_SWEEP_EN
      sweep_q <= sweep_d;
`endif
    end
  end

endmodule

// File: tb/tb_mig_eval_engine.sv
// Directed bench for mig_eval_engine; the sweep section exists only with MIG_EVAL_SWEEP_EN.
module tb_mig_eval_engine;
  import mig_eval_pkg::*;

  localparam int S0 = 0;
  localparam int X0 = 1, X1 = 2, X2 = 3, X3 = 4;
  localparam int N0 = MIG_NUM_IN + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
`ifdef MIG_EVAL_SWEEP_EN
  logic sweep_start = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mig_eval_engine_if bus_if ();

  mig_eval_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef MIG_EVAL_SWEEP_EN
    .sweep_start (sweep_start),
`endif
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic operand_t opd(input logic inv, input int sel);
    operand_t o;
    o.inv = inv;
    o.sel = sel[MIG_SEL_W-1:0];
    return o;
  endfunction

  function automatic gate_t mkg(input operand_t c, input operand_t a, input operand_t b);
    gate_t g;
    g.c = c;
    g.a = a;
    g.b = b;
    return g;
  endfunction

  task automatic wr_gate(input int addr, input gate_t g);
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_addr = addr[MIG_ADDR_W-1:0];
    bus_if.cfg_data = g;
    @(negedge clk);
    bus_if.cfg_we   = 1'b0;
  endtask

  // Present one vector, wait (bounded) for the result, check latency and value.
  task automatic run(input string tag, input logic [MIG_NUM_IN-1:0] x, input int len,
                     input logic inv, input logic exp_bit, input int exp_lat);
    int lat;
    bus_if.in_x        = x;
    bus_if.cfg_len     = len[MIG_LEN_W-1:0];
    bus_if.cfg_out_inv = inv;
    bus_if.in_valid    = 1'b1;
    checki({tag, " in_ready"}, int'(bus_if.in_ready), 1);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.cfg_we   = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checki({tag, " latency"}, lat, exp_lat);
    check1({tag, " out_bit"}, bus_if.out_bit, exp_bit);
    check1({tag, " out_last"}, bus_if.out_last, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic seen;
    bus_if.cfg_we      = 1'b0;
    bus_if.cfg_addr    = '0;
    bus_if.cfg_data    = '0;
    bus_if.cfg_len     = '0;
    bus_if.cfg_out_inv = 1'b0;
    bus_if.in_valid    = 1'b0;
    bus_if.in_x        = '0;
    bus_if.out_ready   = 1'b1;

    repeat (3) @(negedge clk);
    check1("rst in_ready",  bus_if.in_ready,  1'b1);
    check1("rst cfg_ready", bus_if.cfg_ready, 1'b1);
    check1("rst out_valid", bus_if.out_valid, 1'b0);
    check1("rst out_bit",   bus_if.out_bit,   1'b0);
    check1("rst out_last",  bus_if.out_last,  1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 3-input majority
    wr_gate(0, mkg(opd(0, X2), opd(0, X0), opd(0, X1)));
    run("maj011", 7'b0000011, 1, 1'b0, 1'b1, 2);
    run("maj001", 7'b0000001, 1, 1'b0, 1'b0, 2);

    // AND through constant 0
    wr_gate(0, mkg(opd(0, S0), opd(0, X0), opd(0, X1)));
    run("and11",     7'b0000011, 1, 1'b0, 1'b1, 2);
    run("and10",     7'b0000010, 1, 1'b0, 1'b0, 2);
    run("and11_inv", 7'b0000011, 1, 1'b1, 1'b0, 2);

    // Chain: node1 = MAJ(~node0, x3, 0)
    wr_gate(0, mkg(opd(0, X2), opd(0, X0), opd(0, X1)));
    wr_gate(1, mkg(opd(0, S0), opd(1, N0), opd(0, X3)));
    run("chain1111", 7'b0001111, 2, 1'b0, 1'b0, 3);
    run("chain1000", 7'b0001000, 2, 1'b0, 1'b1, 3);

    // Forward reference to node1 (left at 1 above) must read the cleared 0
    wr_gate(0, mkg(opd(0, N0 + 1), opd(0, X0), opd(0, S0)));
    run("fwdref", 7'b0000001, 1, 1'b0, 1'b0, 2);

    // Write coincident with accept: new majority program applies to this vector
    bus_if.cfg_we   = 1'b1;
    bus_if.cfg_addr = '0;
    bus_if.cfg_data = mkg(opd(0, X2), opd(0, X0), opd(0, X1));
    run("coincident", 7'b0000011, 1, 1'b0, 1'b1, 2);

    // Eight-gate program: nodes 0..6 copy x0, node7 = ~node6
    for (int g = 0; g < 7; g++) wr_gate(g, mkg(opd(0, S0), opd(0, X0), opd(0, X0)));
    wr_gate(7, mkg(opd(0, S0), opd(1, N0 + 6), opd(1, N0 + 6)));
    run("clamp_hi", 7'b0000001, 15, 1'b0, 1'b0, 9);
    run("len_zero", 7'b0000001, 0, 1'b0, 1'b1, 2);

    // Backpressure: hold result, drop config writes
    bus_if.out_ready   = 1'b0;
    bus_if.in_x        = '0;
    bus_if.cfg_len     = 4'd8;
    bus_if.cfg_out_inv = 1'b0;
    bus_if.in_valid    = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    lat = 1;
    while (!bus_if.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checki("bp latency", lat, 9);
    for (int k = 0; k < 5; k++) begin
      if (k == 0) begin
        bus_if.cfg_we   = 1'b1;
        bus_if.cfg_addr = 3'd7;
        bus_if.cfg_data = mkg(opd(0, S0), opd(0, X0), opd(0, X0));
      end
      check1("bp out_valid", bus_if.out_valid, 1'b1);
      check1("bp out_bit",   bus_if.out_bit,   1'b1);
      check1("bp in_ready",  bus_if.in_ready,  1'b0);
      check1("bp cfg_ready", bus_if.cfg_ready, 1'b0);
      @(negedge clk);
      bus_if.cfg_we = 1'b0;
    end
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check1("bp release out_valid", bus_if.out_valid, 1'b0);
    run("bp write_dropped", 7'b0000000, 8, 1'b0, 1'b1, 9);

    // Reset during EVAL
    bus_if.in_x     = '0;
    bus_if.cfg_len  = 4'd8;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check1("mid eval in_ready", bus_if.in_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check1("rst async in_ready",  bus_if.in_ready,  1'b1);
    check1("rst async out_valid", bus_if.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.out_valid) seen = 1'b1;
    end
    check1("rst no out_valid pulse", seen, 1'b0);
    run("after reset", 7'b0000000, 8, 1'b0, 1'b1, 9);

`ifdef MIG_EVAL_SWEEP_EN
    begin
      logic [7:0] tt;
      tt = 8'hE8;
      wr_gate(0, mkg(opd(0, X2), opd(0, X0), opd(0, X1)));
      bus_if.cfg_len     = 4'd1;
      bus_if.cfg_out_inv = 1'b0;
      sweep_start        = 1'b1;
      @(negedge clk);
      sweep_start = 1'b0;
      for (int i = 0; i < (1 << MIG_NUM_IN); i++) begin
        lat = 0;
        while (!bus_if.out_valid && lat < 10) begin
          @(negedge clk);
          lat++;
        end
        check1("sweep out_valid", bus_if.out_valid, 1'b1);
        check1("sweep out_bit", bus_if.out_bit, tt[i[2:0]]);
        check1("sweep out_last", bus_if.out_last, (i == (1 << MIG_NUM_IN) - 1));
        check1("sweep in_ready", bus_if.in_ready, 1'b0);
        @(negedge clk);
      end
      check1("sweep end in_ready", bus_if.in_ready, 1'b1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
